// File: rtl/pair_match_detector_pkg.sv
// Shared constants for the pair-match detector: default history length and
// the value the sample history is filled with on reset.
package pair_match_detector_pkg;

    localparam int   SEQ_LEN_DEFAULT = 4;
    localparam int   SEQ_LEN_MIN     = 2;
    // A 1 in the history marks a mismatch, so filling with ones forces z low
    // until a full window of matching samples has been collected.
    localparam logic RST_FILL_BIT    = 1'b1;

endpackage

// File: rtl/pair_match_detector_if.sv
// Signal bundle for the pair-match detector: the two sampled data inputs and
// the match flag.
interface pair_match_detector_if;

    logic w1;
    logic w2;
    logic z;

    modport master (output w1, output w2, input  z);
    modport slave  (input  w1, input  w2, output z);

endinterface

// File: rtl/pair_match_detector_shift_reg_n.sv
// Serial-in, parallel-out shift register with a synchronous reset to a
// configurable value. Bit 0 receives the newest sample.
module pair_match_detector_shift_reg_n #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d    = data_q;
        data_d[0] = din;
        for (int i = 1; i < WIDTH; i++) begin
            data_d[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/pair_match_detector.sv
// Moore-style detector: z is high when w1 and w2 were equal on each of the
// last SEQ_LEN sampled clock edges. SEQ_LEN must be at least 2.
module pair_match_detector
    import pair_match_detector_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    pair_match_detector_if.slave bus
);

    logic               w;
    logic [SEQ_LEN-1:0] hist;

    assign w = bus.w1 ^ bus.w2;

    pair_match_detector_shift_reg_n #(
        .WIDTH   (SEQ_LEN),
        .RST_VAL ({SEQ_LEN{RST_FILL_BIT}})
    ) u_shift (
        .clk  (clk),
        .rst  (rst),
        .din  (w),
        .dout (hist)
    );

    // z depends only on stored history, never directly on w1/w2.
    assign bus.z = ~|hist;

endmodule

// File: tb/tb_pair_match_detector.sv
// Directed bench for pair_match_detector: default (SEQ_LEN=4) and SEQ_LEN=2 builds.
module tb_pair_match_detector;

    logic clk;
    logic rst;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    logic prev_exp;
    bit   pre_en   = 1'b0;

    pair_match_detector_if if4 ();
    pair_match_detector_if if2 ();

    pair_match_detector #(.SEQ_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    pair_match_detector #(.SEQ_LEN(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Drive on the falling edge, check z just before and just after the rising edge.
    task automatic step(input logic a, input logic b, input logic r,
                        input logic exp, input string tag);
        @(negedge clk);
        if (pre_en) chk({tag, "_pre"}, if4.z, prev_exp);
        if4.w1 = a; if4.w2 = b;
        if2.w1 = a; if2.w2 = b;
        rst = r;
        @(posedge clk);
        #1;
        chk(tag, if4.z, exp);
        $display("step %s w1=%b w2=%b rst=%b z=%b exp=%b", tag, a, b, r, if4.z, exp);
        prev_exp = exp;
        pre_en   = 1'b1;
    endtask

    logic [1:0] seq_in  [13] = '{2'b01, 2'b11, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11,
                                 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01};
    logic       seq_exp [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] hist_obs;
    logic [1:0] cur;

    initial begin
        rst = 1'b1;
        if4.w1 = 1'b0; if4.w2 = 1'b0;
        if2.w1 = 1'b0; if2.w2 = 1'b0;

        // 1. Reset for two edges
        step(1'b0, 1'b0, 1'b1, 1'b0, "reset_e1");
        step(1'b0, 1'b0, 1'b1, 1'b0, "reset_e2");
        hist_obs = dut.u_shift.data_q;
        chk("reset_hist_all_ones", hist_obs[0], 1'b1);
        chk("reset_hist_msb",      hist_obs[3], 1'b1);
        chk("reset_z_len2",        if2.z,       1'b0);

        // 2. Sample sequence from release of reset
        for (int i = 0; i < 13; i++) begin
            cur = seq_in[i];
            step(cur[1], cur[0], 1'b0, seq_exp[i], $sformatf("seq_e%0d", i + 1));
        end

        // 3. Short runs: 3 matches then a mismatch, twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++)
                step(1'b1, 1'b1, 1'b0, 1'b0, $sformatf("short_r%0d_m%0d", r, i));
            step(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("short_r%0d_mis", r));
        end

        // 4. Long run of 10 matches
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 1'b0, (i >= 3) ? 1'b1 : 1'b0, $sformatf("long_m%0d", i));

        // 5. Mid-run reset while z=1
        step(1'b1, 1'b1, 1'b1, 1'b0, "midrst_edge");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, (i == 3) ? 1'b1 : 1'b0, $sformatf("midrst_m%0d", i));

        // 6. SEQ_LEN=2 build: reset, match, match, mismatch
        step(1'b0, 1'b0, 1'b1, 1'b0, "len2_rst");
        chk("len2_after_rst", if2.z, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "len2_m1");
        chk("len2_z_m1", if2.z, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, "len2_m2");
        chk("len2_z_m2", if2.z, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, "len2_mis");
        chk("len2_z_mis", if2.z, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
